// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/I-O responder: bus encodings, address map and read-source select.
package mem_io_responder_pkg;
  localparam logic READ_SIGNAL  = 1'b0;
  localparam logic WRITE_SIGNAL = 1'b1;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] addr_t;

  localparam addr_t      IO_BASE = 32'h30000;
  localparam logic [2:0] IO_UART = 3'h0;
  localparam logic [2:0] IO_HALT = 3'h4;
  localparam logic [2:0] IO_STAT = 3'h0;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_IO
  } rd_src_e;
endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between the cache (master) and the memory/I-O responder (slave).
interface mem_io_responder_if
  import mem_io_responder_pkg::*;
  ();
  addr_t addr_in;
  logic  r_nw_in;
  byte_t wdata_in;
  byte_t rdata_out;

  modport master (output addr_in, r_nw_in, wdata_in, input rdata_out);
  modport slave  (input addr_in, r_nw_in, wdata_in, output rdata_out);
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with first-word-fall-through head; a push on a full FIFO is accepted only alongside a pop.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t head,
  output logic  full,
  output logic  empty
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  byte_t              mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// Bus target serving RAM and memory-mapped UART/status/halt registers with one-cycle read latency.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  mem_io_responder_if.slave bus,
  output byte_t tx_data,
  output logic  tx_valid,
  input  logic  tx_ready,
  input  byte_t rx_data,
  input  logic  rx_valid,
  output logic  rx_ready,
  output logic  tx_overflow,
  output logic  halt,
  output byte_t exit_code
);
  byte_t             ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_a;
  logic              we;
  logic              io_sel;
  logic              io_ok;
  logic              uart_sel;
  logic              halt_sel;
  logic              stat_sel;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  byte_t             rx_head;
  byte_t             io_rdata;
  byte_t             ram_q_p1;
  byte_t             io_q_p1;
  rd_src_e           src_p1;
  logic              unused_addr;

  assign unused_addr = ^bus.addr_in[31:18];

  // Request decode (stage p0)
  assign ram_a    = bus.addr_in[RAM_AW-1:0];
  assign we       = (bus.r_nw_in == WRITE_SIGNAL);
  assign io_sel   = bus.addr_in[17];
  assign io_ok    = io_sel && (bus.addr_in[16:4] == IO_BASE[16:4]);
  assign uart_sel = io_ok && !bus.addr_in[3] && (bus.addr_in[2:0] == IO_UART);
  assign halt_sel = io_ok && !bus.addr_in[3] && (bus.addr_in[2:0] == IO_HALT);
  assign stat_sel = io_ok &&  bus.addr_in[3] && (bus.addr_in[2:0] == IO_STAT);

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign tx_push  = rdy && uart_sel && we;
  assign tx_pop   = rdy && tx_valid && tx_ready;
  assign rx_push  = rdy && rx_valid && rx_ready;
  assign rx_pop   = rdy && uart_sel && (bus.r_nw_in == READ_SIGNAL) && !rx_empty;

  always_comb begin
    io_rdata = '0;
    if (uart_sel && !rx_empty) io_rdata = rx_head;
    else if (stat_sel)         io_rdata = {6'b0, !rx_empty, tx_full};
  end

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.wdata_in),
    .head(tx_data), .full(tx_full), .empty(tx_empty)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Response registers (stage p1); RAM and I/O data carry no reset, the source select does
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (we && !io_sel) ram[ram_a] <= bus.wdata_in;
      ram_q_p1 <= ram[ram_a];
      io_q_p1  <= io_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_p1      <= SRC_ZERO;
      halt        <= 1'b0;
      exit_code   <= '0;
      tx_overflow <= 1'b0;
    end else if (rdy) begin
      if (we)          src_p1 <= SRC_ZERO;
      else if (io_sel) src_p1 <= SRC_IO;
      else             src_p1 <= SRC_RAM;
      if (halt_sel && we) begin
        halt      <= 1'b1;
        exit_code <= bus.wdata_in;
      end
      if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  always_comb begin
    case (src_p1)
      SRC_RAM: bus.rdata_out = ram_q_p1;
      SRC_IO:  bus.rdata_out = io_q_p1;
      default: bus.rdata_out = '0;
    endcase
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: the driver queues expected read bytes and TX bytes, monitors compare.
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  logic  clk = 1'b0;
  logic  rst, rdy;
  byte_t tx_data, rx_data, exit_code;
  logic  tx_valid, tx_ready, rx_valid, rx_ready, tx_overflow, halt;

  always #5 clk = ~clk;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_overflow(tx_overflow), .halt(halt), .exit_code(exit_code)
  );

  typedef struct {
    logic  chk;
    byte_t exp;
    string name;
  } rexp_t;

  rexp_t rq[$];
  byte_t txq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end
  endtask

  // One request cycle; the expectation is queued once the capturing edge has passed.
  task automatic cyc(input logic [31:0] a, input logic rnw, input byte_t wd,
                     input logic chk, input byte_t exp, input string name);
    bus.addr_in  = a;
    bus.r_nw_in  = rnw;
    bus.wdata_in = wd;
    @(posedge clk);
    rq.push_back('{chk, exp, name});
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input byte_t d, input string name);
    cyc(a, WRITE_SIGNAL, d, 1'b1, 8'h00, name);
  endtask

  task automatic rd(input logic [31:0] a, input byte_t exp, input string name);
    cyc(a, READ_SIGNAL, 8'h00, 1'b1, exp, name);
  endtask

  task automatic idle();
    cyc(32'h0, READ_SIGNAL, 8'h00, 1'b0, 8'h00, "idle");
  endtask

  always @(negedge clk) begin
    rexp_t e;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      if (e.chk) check8(e.name, bus.rdata_out, e.exp);
    end
  end

  always @(negedge clk) begin
    if (rdy && !rst && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=0x%02h required=none", tx_data);
      end else begin
        check8("tx_data", tx_data, txq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus.addr_in = 32'h0; bus.r_nw_in = READ_SIGNAL; bus.wdata_in = 8'h00;
    cyc(32'h0, READ_SIGNAL, 8'h00, 1'b1, 8'h00, "reset_rdata");
    cyc(32'h0, READ_SIGNAL, 8'h00, 1'b1, 8'h00, "reset_rdata");
    rst = 1'b0;
    check8("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    check8("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
    check8("reset_overflow", {7'b0, tx_overflow}, 8'h00);
    check8("reset_halt", {7'b0, halt}, 8'h00);
    check8("reset_exit_code", exit_code, 8'h00);

    // RAM write/read-back, idle address-0 reads
    wr(32'h100, 8'hA5, "ram_wr_rdata");
    rd(32'h100, 8'hA5, "ram_raw");
    wr(32'h0, 8'h5A, "ram_wr0");
    for (int i = 0; i < 3; i++) rd(32'h0, 8'h5A, "idle_read0");
    check8("idle_tx_valid", {7'b0, tx_valid}, 8'h00);
    rd(32'h30008, 8'h00, "idle_status");

    // TX 'H','i' held, then released
    wr(32'h30000, 8'h48, "tx_wr_h"); txq.push_back(8'h48);
    wr(32'h30000, 8'h69, "tx_wr_i"); txq.push_back(8'h69);
    check8("tx_valid_held", {7'b0, tx_valid}, 8'h01);
    check8("tx_head_h", tx_data, 8'h48);
    tx_ready = 1'b1;
    repeat (3) idle();
    tx_ready = 1'b0;
    check8("tx_valid_drained", {7'b0, tx_valid}, 8'h00);

    // TX overflow on the 17th byte
    for (int i = 0; i < 17; i++) begin
      wr(32'h30000, byte_t'(8'h40 + i), "tx_fill");
      if (i < 16) txq.push_back(byte_t'(8'h40 + i));
      if (i == 15) check8("no_overflow_at_16", {7'b0, tx_overflow}, 8'h00);
    end
    check8("overflow_at_17", {7'b0, tx_overflow}, 8'h01);
    rd(32'h30008, 8'h01, "status_tx_full");
    tx_ready = 1'b1;
    repeat (17) idle();
    tx_ready = 1'b0;
    check8("tx_queue_drained", 8'(txq.size()), 8'h00);
    check8("overflow_sticky", {7'b0, tx_overflow}, 8'h01);

    // RX pushes, pops, empty read, push+pop on empty
    rx_valid = 1'b1; rx_data = 8'h31; idle();
    rx_data = 8'h32; idle();
    rx_valid = 1'b0;
    rd(32'h30008, 8'h02, "status_rx_nonempty");
    rd(32'h30000, 8'h31, "rx_pop_1");
    rd(32'h30000, 8'h32, "rx_pop_2");
    rd(32'h30000, 8'h00, "rx_pop_empty");
    rd(32'h30008, 8'h00, "status_rx_empty");
    rx_valid = 1'b1; rx_data = 8'h55;
    rd(32'h30000, 8'h00, "rx_pushpop_empty");
    rx_valid = 1'b0;
    rd(32'h30000, 8'h55, "rx_pushed_kept");

    // Halt, service after halt, reset in the middle of a TX burst
    wr(32'h30004, 8'h07, "halt_wr");
    check8("halt_set", {7'b0, halt}, 8'h01);
    check8("exit_code", exit_code, 8'h07);
    rd(32'h100, 8'hA5, "served_after_halt");
    wr(32'h30000, 8'h61, "tx_burst"); txq.push_back(8'h61);
    wr(32'h30000, 8'h62, "tx_burst"); txq.push_back(8'h62);
    check8("burst_tx_valid", {7'b0, tx_valid}, 8'h01);
    rst = 1'b1;
    cyc(32'h100, READ_SIGNAL, 8'h00, 1'b1, 8'h00, "rdata_in_reset");
    txq.delete();
    rst = 1'b0;
    check8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check8("rst_halt", {7'b0, halt}, 8'h00);
    check8("rst_exit_code", exit_code, 8'h00);
    check8("rst_overflow", {7'b0, tx_overflow}, 8'h00);

    // rdy=0 freezes RAM, FIFOs and rdata_out
    wr(32'h200, 8'h22, "ram_wr_200");
    rd(32'h100, 8'hA5, "pre_freeze");
    rdy = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
    cyc(32'h200, WRITE_SIGNAL, 8'h11, 1'b1, 8'hA5, "frozen_rdata_wr");
    cyc(32'h0, READ_SIGNAL, 8'h00, 1'b1, 8'hA5, "frozen_rdata_rd");
    rdy = 1'b1; rx_valid = 1'b0;
    rd(32'h200, 8'h22, "ram_unchanged");
    rd(32'h30008, 8'h00, "rx_empty_after_freeze");
    rd(32'h30000, 8'h00, "rx_no_data");

    repeat (2) idle();
    check8("tx_queue_final", 8'(txq.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
